dm_bus_ctrl: RTL and testbench

Data-memory bus controller between the single-cycle RV32I core's load/store path and a handshaked word-wide data memory. It latches one core access (DmWr/DmCtrl/address/store data) and sequences one or two word transactions with byte strobes. It stalls the core until the access completes and returns sign- or zero-extended load data. It also detects misaligned or illegal accesses and memory timeouts.

---
 rtl/dm_bus_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_dm_bus_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_bus_ctrl.sv
// dm_bus_ctrl
//
// Data-memory bus controller sitting between the core's load/store path and
// a handshaked word-wide data memory. One core access is latched in IDLE and
// turned into one or two word beats with byte strobes. The core is stalled
// until the access finishes. Load data comes back sign- or zero-extended.
// Illegal size codes, misaligned accesses and beat timeouts are reported as
// faults.
//
// Build option:
//   DM_MISALIGN_SPLIT_EN  defined   -> misaligned accesses are served, split
//                                      into two beats when they cross a word
//                                      boundary
//                         undefined -> any misaligned access faults with no beat
//
// Parameter:
//   TIMEOUT_CYC  cycles without mem_ack inside one beat before a timeout fault
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid              core access present (held until done)
//   DmWr, DmCtrl           store/load select, size/sign code
//   addr, wdata            byte address, store data
//   stall                  req_valid & ~done (combinational)
//   done, fault, rdata     completion pulse, fault flag, extended load data
//   mem_req, mem_we        beat request, write enable
//   mem_addr               word address of the current beat
//   mem_wstrb, mem_wdata   byte strobes, lane-aligned store data
//   mem_ack, mem_rdata     beat completion, read word
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for req_valid; captures the access and decodes it
// ACC0  | first (or only) beat in flight, mem_req high
// ACC1  | second beat of a word-crossing access, mem_req high
// RESP  | done pulse with fault/rdata, back to IDLE next cycle

module dm_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        DmWr,
    input  logic [2:0]  DmCtrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TMR_LOAD = CW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic          cap_we_q,    cap_we_d;
    logic [2:0]    cap_ctrl_q,  cap_ctrl_d;
    logic [31:0]   cap_addr_q,  cap_addr_d;
    logic [31:0]   cap_wdata_q, cap_wdata_d;
    logic [CW-1:0] tmr_q,       tmr_d;
    logic [31:0]   d0_q,        d0_d;
    logic          fault_q,     fault_d;
    logic [31:0]   rdata_q,     rdata_d;
    logic [31:0]   maddr_q,     maddr_d;
    logic          mwe_q,       mwe_d;
    logic [3:0]    mstrb_q,     mstrb_d;
    logic [31:0]   mwdata_q,    mwdata_d;

    // Decode source: live core inputs while IDLE (capture cycle), the
    // captured copy afterwards so later core-side changes are ignored.
    logic        src_we;
    logic [2:0]  src_ctrl;
    logic [31:0] src_addr;
    logic [31:0] src_wdata;

    always_comb begin
        if (state_q == IDLE) begin
            src_we    = DmWr;
            src_ctrl  = DmCtrl;
            src_addr  = addr;
            src_wdata = wdata;
        end else begin
            src_we    = cap_we_q;
            src_ctrl  = cap_ctrl_q;
            src_addr  = cap_addr_q;
            src_wdata = cap_wdata_q;
        end
    end

    logic [1:0]  off;
    logic [7:0]  lane_mask;
    logic [7:0]  span;
    logic [31:0] rep;
    logic [31:0] lane_data;
    logic        legal;
    logic        misalign;
    logic        split;
    logic [31:0] word0;
    logic [31:0] word1;

    always_comb begin
        off = src_addr[1:0];
        case (src_ctrl[1:0])
            2'b00: begin
                lane_mask = 8'h01;
                rep       = {4{src_wdata[7:0]}};
            end
            2'b01: begin
                lane_mask = 8'h03;
                rep       = {2{src_wdata[15:0]}};
            end
            default: begin
                lane_mask = 8'h0F;
                rep       = src_wdata;
            end
        endcase

        // span[3:0] are the lanes of beat 0, span[7:4] those of beat 1.
        span = lane_mask << off;

        // Rotating the replicated data by the byte offset lines every byte up
        // with its strobe lane, for aligned and split accesses alike.
        case (off)
            2'd0:    lane_data = rep;
            2'd1:    lane_data = {rep[23:0], rep[31:24]};
            2'd2:    lane_data = {rep[15:0], rep[31:16]};
            default: lane_data = {rep[7:0],  rep[31:8]};
        endcase

        if (src_we)
            legal = src_ctrl inside {3'b000, 3'b001, 3'b010};
        else
            legal = src_ctrl inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

`ifdef DM_MISALIGN_SPLIT_EN
        misalign = 1'b0;
        split    = |span[7:4];
`else
        misalign = ((src_ctrl[1:0] == 2'b01) && off[0]) ||
                   ((src_ctrl[1:0] == 2'b10) && (off != 2'b00));
        split    = 1'b0;
`endif

        word0 = {src_addr[31:2], 2'b00};
        word1 = word0 + 32'd4;
    end

    // Load assembly: low bytes come from beat 0 (held in d0_q when a second
    // beat follows), the spill-over bytes from the word arriving now.
    logic [31:0] d_lo;
    logic [31:0] raw;
    logic [31:0] load_ext;

    always_comb begin
        d_lo = (state_q == ACC1) ? d0_q : mem_rdata;
        case (off)
            2'd0:    raw = d_lo;
            2'd1:    raw = {mem_rdata[7:0],  d_lo[31:8]};
            2'd2:    raw = {mem_rdata[15:0], d_lo[31:16]};
            default: raw = {mem_rdata[23:0], d_lo[31:24]};
        endcase
        case (src_ctrl)
            3'b000:  load_ext = {{24{raw[7]}}, raw[7:0]};
            3'b001:  load_ext = {{16{raw[15]}}, raw[15:0]};
            3'b100:  load_ext = {24'd0, raw[7:0]};
            3'b101:  load_ext = {16'd0, raw[15:0]};
            default: load_ext = raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cap_we_q    <= 1'b0;
            cap_ctrl_q  <= 3'b000;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            tmr_q       <= '0;
            d0_q        <= '0;
            fault_q     <= 1'b0;
            rdata_q     <= '0;
            maddr_q     <= '0;
            mwe_q       <= 1'b0;
            mstrb_q     <= 4'b0000;
            mwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            cap_we_q    <= cap_we_d;
            cap_ctrl_q  <= cap_ctrl_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
            tmr_q       <= tmr_d;
            d0_q        <= d0_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
            maddr_q     <= maddr_d;
            mwe_q       <= mwe_d;
            mstrb_q     <= mstrb_d;
            mwdata_q    <= mwdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cap_we_d    = cap_we_q;
        cap_ctrl_d  = cap_ctrl_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        tmr_d       = tmr_q;
        d0_d        = d0_q;
        fault_d     = fault_q;
        rdata_d     = rdata_q;
        maddr_d     = maddr_q;
        mwe_d       = mwe_q;
        mstrb_d     = mstrb_q;
        mwdata_d    = mwdata_q;

        case (state_q)
            IDLE: begin
                fault_d = 1'b0;
                rdata_d = '0;
                if (req_valid) begin
                    cap_we_d    = DmWr;
                    cap_ctrl_d  = DmCtrl;
                    cap_addr_d  = addr;
                    cap_wdata_d = wdata;
                    if (!legal || misalign) begin
                        state_d = RESP;
                        fault_d = 1'b1;
                    end else begin
                        state_d  = ACC0;
                        tmr_d    = TMR_LOAD;
                        maddr_d  = word0;
                        mwe_d    = DmWr;
                        mstrb_d  = DmWr ? span[3:0] : 4'b0000;
                        mwdata_d = DmWr ? lane_data : '0;
                    end
                end
            end

            ACC0, ACC1: begin
                if (mem_ack) begin
                    if (state_q == ACC0)
                        d0_d = mem_rdata;
                    if ((state_q == ACC0) && split) begin
                        // Store data stays put: the rotation already placed the
                        // spill-over bytes in the low lanes.
                        state_d = ACC1;
                        tmr_d   = TMR_LOAD;
                        maddr_d = word1;
                        mstrb_d = cap_we_q ? span[7:4] : 4'b0000;
                    end else begin
                        state_d  = RESP;
                        rdata_d  = cap_we_q ? '0 : load_ext;
                        maddr_d  = '0;
                        mwe_d    = 1'b0;
                        mstrb_d  = 4'b0000;
                        mwdata_d = '0;
                    end
                end else if (tmr_q == '0) begin
                    state_d  = RESP;
                    fault_d  = 1'b1;
                    rdata_d  = '0;
                    maddr_d  = '0;
                    mwe_d    = 1'b0;
                    mstrb_d  = 4'b0000;
                    mwdata_d = '0;
                end else begin
                    tmr_d = tmr_q - CW'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
                fault_d = 1'b0;
                rdata_d = '0;
            end

            default: state_d = IDLE;
        endcase
    end

    assign mem_req   = (state_q == ACC0) || (state_q == ACC1);
    assign done      = (state_q == RESP);
    assign stall     = req_valid & ~done;
    assign fault     = fault_q;
    assign rdata     = rdata_q;
    assign mem_we    = mwe_q;
    assign mem_addr  = maddr_q;
    assign mem_wstrb = mstrb_q;
    assign mem_wdata = mwdata_q;

endmodule

// File: tb/tb_dm_bus_ctrl.sv
module tb_dm_bus_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        DmWr;
    logic [2:0]  DmCtrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    dm_bus_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .DmWr      (DmWr),
        .DmCtrl    (DmCtrl),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .fault     (fault),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        fault;
        logic [31:0] rdata;
        int          lat;
        int          nb;
        logic        tmo;
        logic [31:0] b0a;
        logic [3:0]  b0s;
        logic [31:0] b0d;
        logic [31:0] b1a;
        logic [3:0]  b1s;
        logic [31:0] b1d;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [3:0]  s;
        logic [31:0] d;
    } beat_t;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          lat;
    } res_t;

    beat_t exp_beats[$];
    res_t  exp_res[$];
    vec_t  vecs[16];
    int    nv;

    int checks;
    int errors;

    int          cur_delay;
    logic [31:0] cur_rd0;
    logic [31:0] cur_rd1;
    int          beat_idx;
    int          wait_cnt;
    beat_t       rb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] ctrl, input logic [31:0] a,
                                input logic [31:0] wd, input int delay, input logic [31:0] rd0,
                                input logic [31:0] rd1, input logic flt, input logic [31:0] rdat,
                                input int lat, input int nb, input logic tmo,
                                input logic [31:0] b0a, input logic [3:0] b0s, input logic [31:0] b0d,
                                input logic [31:0] b1a, input logic [3:0] b1s, input logic [31:0] b1d);
        vec_t v;
        v.we = we; v.ctrl = ctrl; v.addr = a; v.wdata = wd; v.delay = delay;
        v.rd0 = rd0; v.rd1 = rd1; v.fault = flt; v.rdata = rdat; v.lat = lat;
        v.nb = nb; v.tmo = tmo;
        v.b0a = b0a; v.b0s = b0s; v.b0d = b0d;
        v.b1a = b1a; v.b1s = b1s; v.b1d = b1d;
        return v;
    endfunction

    // Memory responder: checks every request cycle against the front of the
    // expected-beat queue, acks after cur_delay wait cycles.
    always @(negedge clk) begin
        if (rst || !mem_req) begin
            mem_ack   = 1'b0;
            mem_rdata = '0;
            wait_cnt  = 0;
        end else begin
            if (exp_beats.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual addr=%h expected no request", mem_addr);
            end else begin
                rb = exp_beats[0];
                chk("beat_addr", mem_addr, rb.a);
                chk("beat_we", 32'(mem_we), 32'(rb.we));
                chk("beat_wstrb", 32'(mem_wstrb), 32'(rb.s));
                if (rb.we)
                    chk("beat_wdata", mem_wdata, rb.d);
            end
            if (wait_cnt == cur_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = (beat_idx == 0) ? cur_rd0 : cur_rd1;
                beat_idx++;
                wait_cnt  = 0;
                if (exp_beats.size() != 0)
                    void'(exp_beats.pop_front());
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = '0;
                wait_cnt++;
            end
        end
    end

    // Called at a negedge; returns at a negedge one cycle after done.
    task automatic run_vec(input vec_t v);
        beat_t b;
        res_t  r;
        res_t  e;
        int    lat;
        bit    got;
        cur_delay = v.delay;
        cur_rd0   = v.rd0;
        cur_rd1   = v.rd1;
        beat_idx  = 0;
        if (v.nb >= 1) begin
            b.a = v.b0a; b.we = v.we; b.s = v.b0s; b.d = v.b0d;
            exp_beats.push_back(b);
        end
        if (v.nb >= 2) begin
            b.a = v.b1a; b.we = v.we; b.s = v.b1s; b.d = v.b1d;
            exp_beats.push_back(b);
        end
        e.fault = v.fault; e.rdata = v.rdata; e.lat = v.lat;
        exp_res.push_back(e);

        req_valid = 1'b1;
        DmWr      = v.we;
        DmCtrl    = v.ctrl;
        addr      = v.addr;
        wdata     = v.wdata;
        #1 chk("stall_cycle0", 32'(stall), 32'd1);

        got = 1'b0;
        lat = 0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_wait actual=none within %0d cycles expected=%0d", lat, v.lat);
            rst       = 1'b1;
            req_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            exp_beats.delete();
            exp_res.delete();
            return;
        end
        r = exp_res.pop_front();
        chk("latency", 32'(lat), 32'(r.lat));
        chk("fault", 32'(fault), 32'(r.fault));
        chk("rdata", rdata, r.rdata);
        chk("mem_req_at_done", 32'(mem_req), 32'd0);
        chk("stall_at_done", 32'(stall), 32'd0);
        chk("beats_left", 32'(exp_beats.size()), v.tmo ? 32'd1 : 32'd0);
        exp_beats.delete();
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=still running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        DmWr      = 1'b0;
        DmCtrl    = 3'b000;
        addr      = '0;
        wdata     = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        cur_delay = 0;
        cur_rd0   = '0;
        cur_rd1   = '0;
        beat_idx  = 0;
        wait_cnt  = 0;

        nv = 0;
        //             we    ctrl    addr          wdata         dly rd0           rd1           flt rdata         lat nb tmo b0a           b0s      b0d           b1a           b1s      b1d
        vecs[nv++] = mk(1'b1, 3'b010, 32'h00000100, 32'hDEADBEEF, 0, 32'h0,        32'h0,        0, 32'h00000000, 2, 1, 0, 32'h00000100, 4'b1111, 32'hDEADBEEF, 32'h0, 4'b0000, 32'h0);
        vecs[nv++] = mk(1'b0, 3'b000, 32'h00000203, 32'h0,        3, 32'h80FF0000, 32'h0,        0, 32'hFFFFFF80, 5, 1, 0, 32'h00000200, 4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0);
        vecs[nv++] = mk(1'b0, 3'b100, 32'h00000203, 32'h0,        3, 32'h80FF0000, 32'h0,        0, 32'h00000080, 5, 1, 0, 32'h00000200, 4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0);
        vecs[nv++] = mk(1'b1, 3'b001, 32'h00000010, 32'hFFFF1234, 0, 32'h0,        32'h0,        0, 32'h00000000, 2, 1, 0, 32'h00000010, 4'b0011, 32'h12341234, 32'h0, 4'b0000, 32'h0);
        vecs[nv++] = mk(1'b1, 3'b001, 32'h00000012, 32'h0000ABCD, 0, 32'h0,        32'h0,        0, 32'h00000000, 2, 1, 0, 32'h00000010, 4'b1100, 32'hABCDABCD, 32'h0, 4'b0000, 32'h0);
        vecs[nv++] = mk(1'b1, 3'b000, 32'h00000107, 32'hFFFFFF5A, 1, 32'h0,        32'h0,        0, 32'h00000000, 3, 1, 0, 32'h00000104, 4'b1000, 32'h5A5A5A5A, 32'h0, 4'b0000, 32'h0);
        vecs[nv++] = mk(1'b0, 3'b001, 32'h00000102, 32'h0,        1, 32'h80017FFF, 32'h0,        0, 32'hFFFF8001, 3, 1, 0, 32'h00000100, 4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0);
        vecs[nv++] = mk(1'b0, 3'b101, 32'h00000102, 32'h0,        1, 32'h80017FFF, 32'h0,        0, 32'h00008001, 3, 1, 0, 32'h00000100, 4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0);
        vecs[nv++] = mk(1'b0, 3'b010, 32'h00000300, 32'h0,        2, 32'h12345678, 32'h0,        0, 32'h12345678, 4, 1, 0, 32'h00000300, 4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0);
        vecs[nv++] = mk(1'b0, 3'b011, 32'h00000300, 32'h0,        0, 32'h0,        32'h0,        1, 32'h00000000, 1, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0);
        vecs[nv++] = mk(1'b1, 3'b100, 32'h00000300, 32'h000000FF, 0, 32'h0,        32'h0,        1, 32'h00000000, 1, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0);
        vecs[nv++] = mk(1'b0, 3'b010, 32'h00000400, 32'h0,     1000, 32'h0,        32'h0,        1, 32'h00000000, 6, 1, 1, 32'h00000400, 4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0);
`ifdef DM_MISALIGN_SPLIT_EN
        vecs[nv++] = mk(1'b0, 3'b010, 32'h000001FE, 32'h0,        0, 32'hAABBCCDD, 32'h11223344, 0, 32'h3344AABB, 3, 2, 0, 32'h000001FC, 4'b0000, 32'h0,        32'h00000200, 4'b0000, 32'h0);
        vecs[nv++] = mk(1'b1, 3'b010, 32'hFFFFFFFD, 32'h11223344, 0, 32'h0,        32'h0,        0, 32'h00000000, 3, 2, 0, 32'hFFFFFFFC, 4'b1110, 32'h22334411, 32'h00000000, 4'b0001, 32'h22334411);
        vecs[nv++] = mk(1'b1, 3'b001, 32'h00000021, 32'h0000BEEF, 0, 32'h0,        32'h0,        0, 32'h00000000, 2, 1, 0, 32'h00000020, 4'b0110, 32'hEFBEEFBE, 32'h0, 4'b0000, 32'h0);
`else
        vecs[nv++] = mk(1'b0, 3'b010, 32'h000001FE, 32'h0,        0, 32'hAABBCCDD, 32'h11223344, 1, 32'h00000000, 1, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0);
        vecs[nv++] = mk(1'b1, 3'b010, 32'hFFFFFFFD, 32'h11223344, 0, 32'h0,        32'h0,        1, 32'h00000000, 1, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0);
        vecs[nv++] = mk(1'b1, 3'b001, 32'h00000021, 32'h0000BEEF, 0, 32'h0,        32'h0,        1, 32'h00000000, 1, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0);
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        req_valid = 1'b1;
        #1 chk("rst_stall_hi", 32'(stall), 32'd1);
        req_valid = 1'b0;
        #1 chk("rst_stall_lo", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < nv; i++)
            run_vec(vecs[i]);

        // Reset while a beat is waiting for its ack.
        begin
            beat_t b;
            bit    saw_done;
            cur_delay = 1000;
            beat_idx  = 0;
            b.a = 32'h00000500; b.we = 1'b0; b.s = 4'b0000; b.d = 32'h0;
            exp_beats.push_back(b);
            req_valid = 1'b1;
            DmWr      = 1'b0;
            DmCtrl    = 3'b010;
            addr      = 32'h00000500;
            wdata     = 32'h0;
            @(posedge clk);
            @(negedge clk);
            chk("acc0_mem_req", 32'(mem_req), 32'd1);
            @(posedge clk);
            @(negedge clk);
            rst       = 1'b1;
            req_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("rst_abort_mem_req", 32'(mem_req), 32'd0);
            chk("rst_abort_done", 32'(done), 32'd0);
            rst = 1'b0;
            exp_beats.delete();
            saw_done = 1'b0;
            repeat (3) begin
                @(posedge clk);
                @(negedge clk);
                if (done || mem_req) saw_done = 1'b1;
            end
            chk("rst_abort_quiet", 32'(saw_done), 32'd0);
            run_vec(mk(1'b1, 3'b000, 32'h00000003, 32'h00000077, 0, 32'h0, 32'h0, 0, 32'h0, 2, 1, 0,
                       32'h00000000, 4'b1000, 32'h77777777, 32'h0, 4'b0000, 32'h0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
